cpu_sequencer: RTL and testbench

Fetch/decode/execute controller that sits directly upstream of the 4-bit ALU.
- Holds the program counter, the instruction register, a 4x4-bit register file and the C/Z flag registers.
- Fetches 8-bit instructions from a synchronous 16-entry instruction ROM.
- Drives the ALU operands, operation bits and enable, then writes the registered ALU result and flags back.

---
 rtl/cpu_sequencer_if.sv | 33 +++
 rtl/cpu_sequencer.sv | 146 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: ROM fetch, ALU and debug signals of the sequencer.
// master = sequencer side, slave = ROM/ALU/debug environment side.
interface cpu_sequencer_if;
    logic       run;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_enable;
    logic       alu_op_bit0;
    logic       alu_op_bit1;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_z;
    logic       flag_c;
    logic       flag_z;
    logic       halted;
    logic       retire;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;

    modport master (
        input  run, imem_data, alu_result, alu_carry, alu_z, dbg_sel,
        output imem_addr, alu_a, alu_b, alu_enable, alu_op_bit0,
        output alu_op_bit1, flag_c, flag_z, halted, retire, dbg_data
    );

    modport slave (
        output run, imem_data, alu_result, alu_carry, alu_z, dbg_sel,
        input  imem_addr, alu_a, alu_b, alu_enable, alu_op_bit0,
        input  alu_op_bit1, flag_c, flag_z, halted, retire, dbg_data
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for a registered 4-bit ALU.
// Holds PC, IR, a 4x4 register file and the C/Z flags.
module cpu_sequencer #(
    parameter int         DATA_WIDTH = 4,
    parameter logic [3:0] START_PC   = 4'd0
) (
    input logic             clock,
    input logic             reset,
    cpu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            pc_q, pc_d;
    logic [7:0]            ir_q, ir_d;
    logic [DATA_WIDTH-1:0] rf_q [4];
    logic [DATA_WIDTH-1:0] rf_d [4];
    logic                  flag_c_q, flag_c_d;
    logic                  flag_z_q, flag_z_d;
    logic                  retire_q, retire_d;
    logic                  alu_en;

    logic       is_alu, is_ldi, is_jmp, is_sys;
    logic       jmp_take;
    logic [3:0] pc_inc;

    assign is_alu = (ir_q[7:6] == 2'b00);
    assign is_ldi = (ir_q[7:6] == 2'b01);
    assign is_jmp = (ir_q[7:6] == 2'b10);
    assign is_sys = (ir_q[7:6] == 2'b11);
    assign pc_inc = pc_q + 4'd1;

    // Jump condition, evaluated on the flags held at instruction start
    always_comb begin
        jmp_take = 1'b0;
        case (ir_q[5:4])
            2'b00: jmp_take = 1'b1;
            2'b01: jmp_take = flag_z_q;
            2'b10: jmp_take = flag_c_q;
            2'b11: jmp_take = !flag_z_q;
        endcase
    end

    // Next-state, architectural updates and ALU enable
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rf_d     = rf_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        retire_d = 1'b0;
        alu_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = bus.imem_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_alu: begin
                        alu_en  = 1'b1;
                        state_d = S_WB;
                    end
                    is_ldi: begin
                        rf_d[ir_q[5:4]] = ir_q[3:0];
                        pc_d            = pc_inc;
                        retire_d        = 1'b1;
                        state_d         = S_FETCH;
                    end
                    is_jmp: begin
                        pc_d     = jmp_take ? ir_q[3:0] : pc_inc;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    is_sys: begin
                        retire_d = 1'b1;
                        if (ir_q[5]) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_inc;
                            state_d = S_FETCH;
                        end
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                rf_d[ir_q[3:2]] = bus.alu_result;
                flag_c_d        = bus.alu_carry;
                flag_z_d        = bus.alu_z;
                pc_d            = pc_inc;
                retire_d        = 1'b1;
                state_d         = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= START_PC;
            ir_q     <= 8'd0;
            rf_q     <= '{default: '0};
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            rf_q     <= rf_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            retire_q <= retire_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.alu_a       = rf_q[ir_q[3:2]];
    assign bus.alu_b       = rf_q[ir_q[1:0]];
    assign bus.alu_op_bit0 = ir_q[5];
    assign bus.alu_op_bit1 = ir_q[4];
    assign bus.alu_enable  = alu_en;
    assign bus.flag_c      = flag_c_q;
    assign bus.flag_z      = flag_z_q;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.retire      = retire_q;
    assign bus.dbg_data    = rf_q[bus.dbg_sel];

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed program table, corner sequences and random
// programs checked against an instruction-level reference model.
module tb_cpu_sequencer;

    logic clock;
    logic reset;

    cpu_sequencer_if bus ();

    cpu_sequencer #(
        .DATA_WIDTH (4),
        .START_PC   (4'd0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] rom [16];

    // synchronous instruction ROM
    always @(posedge clock) bus.imem_data <= rom[bus.imem_addr];

    // registered 4-bit ALU: 00 ADD, 01 SUB (carry = borrow), 10 AND, 11 OR
    always @(posedge clock) begin
        logic [4:0] s;
        if (bus.alu_enable) begin
            case ({bus.alu_op_bit0, bus.alu_op_bit1})
                2'b00: s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                2'b01: s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                2'b10: s = {1'b0, bus.alu_a & bus.alu_b};
                default: s = {1'b0, bus.alu_a | bus.alu_b};
            endcase
            bus.alu_result <= s[3:0];
            bus.alu_carry  <= s[4];
            bus.alu_z      <= (s[3:0] == 4'd0);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input int e0, input int e1,
                            input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            bus.dbg_sel = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), int'(bus.dbg_data), e[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.run = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // instruction-level reference model
    int m_pc;
    int m_r [4];
    int m_c, m_z, m_halt;

    task automatic model_reset();
        m_pc = 0;
        m_r = '{0, 0, 0, 0};
        m_c = 0;
        m_z = 0;
        m_halt = 0;
    endtask

    task automatic model_step(input logic [7:0] ir, output int lat);
        int a, b, res, cc, take;
        lat = 3;
        case (ir[7:6])
            2'b00: begin
                a = m_r[ir[3:2]];
                b = m_r[ir[1:0]];
                case (ir[5:4])
                    2'b00: begin res = (a + b) % 16; m_c = (a + b > 15); end
                    2'b01: begin res = (a - b + 16) % 16; m_c = (a < b); end
                    2'b10: begin res = a & b; m_c = 0; end
                    default: begin res = a | b; m_c = 0; end
                endcase
                m_z = (res == 0);
                m_r[ir[3:2]] = res;
                m_pc = (m_pc + 1) % 16;
                lat = 4;
            end
            2'b01: begin
                m_r[ir[5:4]] = int'(ir[3:0]);
                m_pc = (m_pc + 1) % 16;
            end
            2'b10: begin
                cc = int'(ir[5:4]);
                take = (cc == 0) || (cc == 1 && m_z == 1) ||
                       (cc == 2 && m_c == 1) || (cc == 3 && m_z == 0);
                m_pc = take ? int'(ir[3:0]) : (m_pc + 1) % 16;
            end
            default: begin
                if (ir[5]) m_halt = 1;
                else m_pc = (m_pc + 1) % 16;
            end
        endcase
    endtask

    typedef struct {
        int r0, r1, r2, r3;
        int c, z, pc, ret, en, ops;
    } exp_t;

    logic [7:0] progs [5][16];
    exp_t       ev [5];

    initial begin
        int cyc, n_ret, n_en, ops, last, lat, steps, en_cnt, first;
        logic [7:0] ir;
        reset = 1'b1;
        bus.run = 1'b0;
        bus.dbg_sel = 2'd0;
        for (int i = 0; i < 16; i++) rom[i] = 8'hC0;

        for (int v = 0; v < 5; v++)
            for (int i = 0; i < 16; i++) progs[v][i] = 8'hC0;
        progs[0][0] = 8'h45; progs[0][1] = 8'h53;
        progs[0][2] = 8'h01; progs[0][3] = 8'hE0;
        ev[0] = '{8, 3, 0, 0, 0, 0, 3, 4, 1, 0};
        progs[1][0] = 8'h49; progs[1][1] = 8'h59;
        progs[1][2] = 8'h11; progs[1][3] = 8'h9A;
        progs[1][10] = 8'hE0;
        ev[1] = '{0, 9, 0, 0, 0, 1, 10, 5, 1, 1};
        progs[2][0] = 8'h6F; progs[2][1] = 8'h71;
        progs[2][2] = 8'h0B; progs[2][3] = 8'h64;
        progs[2][4] = 8'hE0;
        ev[2] = '{0, 0, 4, 1, 1, 1, 4, 5, 1, 0};
        progs[3][0] = 8'h4C; progs[3][1] = 8'h5A;
        progs[3][2] = 8'h21; progs[3][3] = 8'h4C;
        progs[3][4] = 8'h31; progs[3][5] = 8'hE0;
        ev[3] = '{14, 10, 0, 0, 0, 0, 5, 6, 2, 11};
        progs[4][0] = 8'h41; progs[4][1] = 8'hA5;
        progs[4][2] = 8'hE0; progs[4][5] = 8'h77;
        progs[4][6] = 8'hE0;
        ev[4] = '{1, 0, 0, 0, 0, 0, 2, 3, 0, 0};

        // reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_pc", int'(bus.imem_addr), 0);
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_retire", int'(bus.retire), 0);
        chk("rst_alu_en", int'(bus.alu_enable), 0);
        chk("rst_fc", int'(bus.flag_c), 0);
        chk("rst_fz", int'(bus.flag_z), 0);
        chk_regs("rst", 0, 0, 0, 0);
        reset = 1'b0;
        n_ret = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_ret += int'(bus.retire) + int'(bus.alu_enable);
        end
        chk("idle_hold_pc", int'(bus.imem_addr), 0);
        chk("idle_no_activity", n_ret, 0);

        // directed program table
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 16; i++) rom[i] = progs[v][i];
            do_reset();
            bus.run = 1'b1;
            cyc = 0; n_ret = 0; n_en = 0; ops = 0;
            while (!bus.halted && cyc < 200) begin
                @(negedge clock);
                cyc++;
                if (bus.retire) n_ret++;
                if (bus.alu_enable) begin
                    n_en++;
                    ops = ((ops << 2) & 12) |
                          {bus.alu_op_bit0, bus.alu_op_bit1};
                end
            end
            chk($sformatf("v%0d_halted", v), int'(bus.halted), 1);
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                if (bus.retire) n_ret++;
                if (bus.alu_enable) n_en++;
            end
            chk($sformatf("v%0d_still_halted", v), int'(bus.halted), 1);
            chk($sformatf("v%0d_retires", v), n_ret, ev[v].ret);
            chk($sformatf("v%0d_alu_en", v), n_en, ev[v].en);
            chk($sformatf("v%0d_ops", v), ops, ev[v].ops);
            chk($sformatf("v%0d_pc", v), int'(bus.imem_addr), ev[v].pc);
            chk($sformatf("v%0d_fc", v), int'(bus.flag_c), ev[v].c);
            chk($sformatf("v%0d_fz", v), int'(bus.flag_z), ev[v].z);
            chk_regs($sformatf("v%0d", v), ev[v].r0, ev[v].r1,
                     ev[v].r2, ev[v].r3);
            bus.run = 1'b0;
        end

        // PC wrap over a ROM of NOPs
        for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
        do_reset();
        bus.run = 1'b1;
        cyc = 0; n_ret = 0; last = 0;
        while (n_ret < 16 && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (bus.retire) begin
                n_ret++;
                if (n_ret > 1) chk("wrap_spacing", cyc - last, 3);
                last = cyc;
            end
        end
        chk("wrap_count", n_ret, 16);
        chk("wrap_pc", int'(bus.imem_addr), 0);
        bus.run = 1'b0;

        // reset during EXEC of an ADD
        for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
        rom[0] = 8'h55;
        rom[1] = 8'h01;
        do_reset();
        bus.run = 1'b1;
        cyc = 0;
        while (!bus.alu_enable && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        chk("rx_saw_exec", int'(bus.alu_enable), 1);
        reset = 1'b1;
        bus.run = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("rx_alu_en", int'(bus.alu_enable), 0);
        chk("rx_pc", int'(bus.imem_addr), 0);
        chk("rx_retire", int'(bus.retire), 0);
        chk_regs("rx", 0, 0, 0, 0);
        n_ret = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_ret += int'(bus.retire) + int'(bus.alu_enable);
        end
        chk("rx_idle_quiet", n_ret, 0);
        chk("rx_idle_pc", int'(bus.imem_addr), 0);
        chk("rx_fc", int'(bus.flag_c), 0);
        bus.run = 1'b1;
        @(negedge clock);
        bus.run = 1'b0;
        cyc = 0;
        while (!bus.halted && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        chk("rx_restart_halt", int'(bus.halted), 1);
        chk_regs("rx_restart", 5, 5, 0, 0);

        // random programs against the reference model
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 16; i++) begin
                int r;
                logic [5:0] lo;
                r = $urandom_range(0, 99);
                lo = 6'($urandom);
                if (r < 35) rom[i] = {2'b00, lo};
                else if (r < 60) rom[i] = {2'b01, lo};
                else if (r < 80) rom[i] = {2'b10, lo};
                else if (r < 97) rom[i] = {2'b11, 1'b0, lo[4:0]};
                else rom[i] = {2'b11, 1'b1, lo[4:0]};
            end
            model_reset();
            do_reset();
            bus.run = 1'b1;
            cyc = 0; last = 0; steps = 0; en_cnt = 0; first = 1;
            while (steps < 40 && m_halt == 0 && cyc < 250) begin
                @(negedge clock);
                cyc++;
                if (bus.alu_enable) begin
                    en_cnt++;
                    ir = rom[m_pc];
                    chk("rnd_alu_a", int'(bus.alu_a), m_r[ir[3:2]]);
                    chk("rnd_alu_b", int'(bus.alu_b), m_r[ir[1:0]]);
                    chk("rnd_ops", int'({bus.alu_op_bit0, bus.alu_op_bit1}),
                        int'(ir[5:4]));
                end
                if (bus.retire) begin
                    ir = rom[m_pc];
                    model_step(ir, lat);
                    chk("rnd_latency", cyc - last, lat + first);
                    chk("rnd_en_count", en_cnt, (lat == 4) ? 1 : 0);
                    chk("rnd_pc", int'(bus.imem_addr), m_pc);
                    chk("rnd_fc", int'(bus.flag_c), m_c);
                    chk("rnd_fz", int'(bus.flag_z), m_z);
                    chk("rnd_halted", int'(bus.halted), m_halt);
                    chk_regs("rnd", m_r[0], m_r[1], m_r[2], m_r[3]);
                    last = cyc;
                    first = 0;
                    en_cnt = 0;
                    steps++;
                end
            end
            chk("rnd_progress", int'(steps >= 40 || m_halt != 0), 1);
            bus.run = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
